// File: rtl/bomb_game_ctrl.sv
// Bomb game round sequencer: password generation, display handshake,
// timed guess phase and win/detonation verdict.
module bomb_game_ctrl #(
  parameter int TICK_DIV   = 100,
  parameter int INPUT_TIME = 9,
  parameter int MAX_TRIES  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] sw,
  input  logic       confirm,
  input  logic       end_of_show,
  output logic       show_rst,
  output logic       showing,
  output logic [6:0] psw,
  output logic [3:0] time_left,
  output logic [1:0] lives,
  output logic [2:0] phase,
  output logic       win,
  output logic       boom
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_SHOW  = 3'd2,
    S_INPUT = 3'd3,
    S_CHECK = 3'd4,
    S_WIN   = 3'd5,
    S_BOOM  = 3'd6
  } state_t;

  state_t      r_state;
  logic [6:0]  r_lfsr;
  logic [15:0] r_cnt;
  logic [6:0]  r_guess;
  logic        r_show_first;
  logic        w_timed;
  logic        w_tick;

  assign w_timed = (r_state == S_INPUT) || (r_state == S_CHECK);
  assign w_tick  = w_timed && (r_cnt == 16'(TICK_DIV - 1));

  assign phase = r_state;
  assign win   = (r_state == S_WIN);
  assign boom  = (r_state == S_BOOM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= 7'h5A;
    end else begin
      r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
    end
  end

  // Outside the timed phases the count sits at zero, so INPUT entry starts fresh
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!w_timed || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      psw          <= '0;
      time_left    <= '0;
      lives        <= 2'(MAX_TRIES);
      showing      <= 1'b0;
      show_rst     <= 1'b0;
      r_guess      <= '0;
      r_show_first <= 1'b0;
    end else begin
      show_rst <= 1'b0;
      unique case (r_state)
        S_IDLE, S_WIN, S_BOOM: begin
          if (start) begin
            r_state  <= S_GEN;
            show_rst <= 1'b1;
          end
        end
        S_GEN: begin
          psw          <= r_lfsr;
          lives        <= 2'(MAX_TRIES);
          time_left    <= 4'(INPUT_TIME);
          showing      <= 1'b1;
          r_show_first <= 1'b1;
          r_state      <= S_SHOW;
        end
        S_SHOW: begin
          r_show_first <= 1'b0;
          if (!r_show_first && end_of_show) begin
            showing <= 1'b0;
            r_state <= S_INPUT;
          end
        end
        S_INPUT: begin
          if (w_tick) time_left <= time_left - 4'd1;
          if (confirm) begin
            r_guess <= sw;
            r_state <= S_CHECK;
          end else if (w_tick && time_left == 4'd1) begin
            r_state <= S_BOOM;
          end
        end
        S_CHECK: begin
          if (w_tick && time_left != 4'd0)
            time_left <= time_left - 4'd1;
          if (r_guess == psw) begin
            r_state <= S_WIN;
          end else if (lives == 2'd1) begin
            r_state <= S_BOOM;
          end else begin
            lives <= lives - 2'd1;
            // A tick landing in CHECK can also exhaust the clock
            if (time_left == 4'd0 || (w_tick && time_left == 4'd1))
              r_state <= S_BOOM;
            else
              r_state <= S_INPUT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Directed bench for bomb_game_ctrl with TICK_DIV=4, INPUT_TIME=3,
// MAX_TRIES=3; expected values are hand-derived cycle by cycle.
module tb_bomb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] sw = '0;
  logic       confirm = 1'b0;
  logic       end_of_show = 1'b0;
  logic       show_rst;
  logic       showing;
  logic [6:0] psw;
  logic [3:0] time_left;
  logic [1:0] lives;
  logic [2:0] phase;
  logic       win;
  logic       boom;

  int n_chk  = 0;
  int n_fail = 0;
  logic [6:0] m_lfsr;
  logic [6:0] exp_psw;

  bomb_game_ctrl #(
    .TICK_DIV(4),
    .INPUT_TIME(3),
    .MAX_TRIES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sw(sw),
    .confirm(confirm),
    .end_of_show(end_of_show),
    .show_rst(show_rst),
    .showing(showing),
    .psw(psw),
    .time_left(time_left),
    .lives(lives),
    .phase(phase),
    .win(win),
    .boom(boom)
  );

  always #5 clk = ~clk;

  // Reference x^7+x^6+1 sequence from the 7'h5A seed
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 7'h5A;
    else      m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " psw"}, 32'(psw), 32'd0);
    check({tag, " time_left"}, 32'(time_left), 32'd0);
    check({tag, " lives"}, 32'(lives), 32'd3);
    check({tag, " phase"}, 32'(phase), 32'd0);
    check({tag, " showing"}, 32'(showing), 32'd0);
    check({tag, " show_rst"}, 32'(show_rst), 32'd0);
    check({tag, " win"}, 32'(win), 32'd0);
    check({tag, " boom"}, 32'(boom), 32'd0);
  endtask

  // Start a round with end_of_show already high at GEN; leaves the
  // bench in the first INPUT cycle
  task automatic enter_input();
    start = 1'b1;
    step();
    start = 1'b0;
    check("gen phase", 32'(phase), 32'd1);
    check("gen show_rst", 32'(show_rst), 32'd1);
    exp_psw = m_lfsr;
    end_of_show = 1'b1;
    step();
    check("show1 phase", 32'(phase), 32'd2);
    check("show1 showing", 32'(showing), 32'd1);
    check("show1 show_rst", 32'(show_rst), 32'd0);
    check("show1 psw", 32'(psw), 32'(exp_psw));
    check("show1 time_left", 32'(time_left), 32'd3);
    check("show1 lives", 32'(lives), 32'd3);
    step();
    check("show2 phase", 32'(phase), 32'd2);
    start = 1'b1;
    step();
    start = 1'b0;
    end_of_show = 1'b0;
    check("input phase", 32'(phase), 32'd3);
    check("input showing", 32'(showing), 32'd0);
  endtask

  initial begin
    #3 rst = 1'b0;
    step(2);
    check_reset_vals("por");
    rst = 1'b1;
    step();
    check("idle phase", 32'(phase), 32'd0);

    // 1/2: start, long show, correct guess
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1 gen phase", 32'(phase), 32'd1);
    check("t1 show_rst", 32'(show_rst), 32'd1);
    exp_psw = m_lfsr;
    step();
    check("t1 phase", 32'(phase), 32'd2);
    check("t1 showing", 32'(showing), 32'd1);
    check("t1 show_rst low", 32'(show_rst), 32'd0);
    check("t1 psw", 32'(psw), 32'(exp_psw));
    check("t1 psw nonzero", 32'(psw != 7'd0), 32'd1);
    step(9);
    check("t2 still show", 32'(phase), 32'd2);
    end_of_show = 1'b1;
    step();
    end_of_show = 1'b0;
    check("t2 input", 32'(phase), 32'd3);
    check("t2 showing off", 32'(showing), 32'd0);
    sw = exp_psw;
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    check("t2 check", 32'(phase), 32'd4);
    step();
    check("t2 win phase", 32'(phase), 32'd5);
    check("t2 win", 32'(win), 32'd1);
    check("t2 lives", 32'(lives), 32'd3);
    check("t2 boom", 32'(boom), 32'd0);

    // 3: three wrong guesses
    enter_input();
    sw = exp_psw ^ 7'h01;
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    check("t3 check1", 32'(phase), 32'd4);
    step();
    check("t3 back1", 32'(phase), 32'd3);
    check("t3 lives2", 32'(lives), 32'd2);
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    step();
    check("t3 back2", 32'(phase), 32'd3);
    check("t3 lives1", 32'(lives), 32'd1);
    check("t3 time2", 32'(time_left), 32'd2);
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    check("t3 check3", 32'(phase), 32'd4);
    step();
    check("t3 boom phase", 32'(phase), 32'd6);
    check("t3 boom", 32'(boom), 32'd1);
    check("t3 lives frozen", 32'(lives), 32'd1);
    step(5);
    check("t3 lives hold", 32'(lives), 32'd1);
    check("t3 time hold", 32'(time_left), 32'd2);
    check("t3 boom hold", 32'(phase), 32'd6);

    // 4: timeout
    enter_input();
    check("t4 tl3", 32'(time_left), 32'd3);
    step(3);
    check("t4 tl3 late", 32'(time_left), 32'd3);
    step();
    check("t4 tl2", 32'(time_left), 32'd2);
    step(4);
    check("t4 tl1", 32'(time_left), 32'd1);
    step(3);
    check("t4 pre boom", 32'(phase), 32'd3);
    step();
    check("t4 boom at 12", 32'(phase), 32'd6);
    check("t4 tl0", 32'(time_left), 32'd0);
    check("t4 boom", 32'(boom), 32'd1);

    // 5: confirm on the final tick
    enter_input();
    step(11);
    sw = exp_psw;
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    check("t5a check", 32'(phase), 32'd4);
    check("t5a tl0", 32'(time_left), 32'd0);
    step();
    check("t5a win", 32'(phase), 32'd5);
    check("t5a tl0 win", 32'(time_left), 32'd0);
    enter_input();
    step(11);
    sw = exp_psw ^ 7'h10;
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    check("t5b check", 32'(phase), 32'd4);
    step();
    check("t5b boom", 32'(phase), 32'd6);
    check("t5b boom flag", 32'(boom), 32'd1);

    // 6: asynchronous reset mid-INPUT, then a fresh round
    enter_input();
    step(2);
    #2 rst = 1'b0;
    #1 check_reset_vals("async");
    step();
    rst = 1'b1;
    step();
    check("t6 idle", 32'(phase), 32'd0);
    enter_input();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
